// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect on the synchronized value.
// Latency: rx_s lags rx_in by SYNC_DEPTH cycles; fall_edge is high in the cycle rx_s first reads 0.
// Backpressure: none; free-running.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic rx_in,
    output logic rx_s,
    output logic fall_edge
);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  r_prev;

    // Shift the raw line through the sync chain and remember the last synchronized value.
    // Flops reset to 1 so an idle-high line never produces a spurious edge at reset release.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], rx_in};
            r_prev <= r_sync[SYNC_DEPTH-1];
        end
    end

    assign rx_s      = r_sync[SYNC_DEPTH-1];
    assign fall_edge = r_prev & ~r_sync[SYNC_DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit; even parity when UART_RX_PARITY_EN is defined.
// Latency: rx_valid/rx_data update one cycle after the stop-bit midpoint sample.
// Backpressure: none on the line; an unacknowledged byte is overwritten and rx_overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BPS_PARA = 5208
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rx_in,
    input  logic              rx_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    output logic              rx_parity_err,
    output logic              rx_busy
);

    localparam logic [15:0] BPS_LAST  = 16'(BPS_PARA - 1);
    localparam logic [15:0] SAMPLE_PT = 16'(BPS_PARA >> 1);

    logic              w_rx_s;
    logic              w_fall;
    logic              w_sample;
    logic              w_accept;

    uart_state_t       r_state;
    logic [15:0]       r_cnt;
    logic [2:0]        r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_overrun;
    logic              r_busy;

    uart_rx_sync u_sync (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rx_in     (rx_in),
        .rx_s      (w_rx_s),
        .fall_edge (w_fall)
    );

    assign w_sample = (r_cnt == SAMPLE_PT);
    assign w_accept = (r_state == ST_STOP) && w_sample && w_rx_s;

    // Bit-period counter: realigned on the start edge so the sample point lands mid-bit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt <= 16'd0;
        end else if ((r_state == ST_IDLE) && w_fall) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == BPS_LAST) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Output handshake: a new byte wins over a same-cycle ack; overrun only if the old byte is still pending.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_accept & r_valid & ~rx_ack;
            if (w_accept) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (rx_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_parity_err;

    // Receive FSM with the parity bit sampled between the data and stop bits.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= '0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= 3'd0;
                    end
                end
                ST_START: begin
                    if (w_sample) begin
                        if (!w_rx_s) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {w_rx_s, r_shift[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_sample) begin
                        r_par   <= w_rx_s;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_sample) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_err  <= ~w_rx_s;
                        r_parity_err <= ^{r_shift, r_par};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_parity_err = r_parity_err;
`else
    // Receive FSM: start qualification, eight data bits, stop-bit check.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= 3'd0;
                    end
                end
                ST_START: begin
                    if (w_sample) begin
                        if (!w_rx_s) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {w_rx_s, r_shift[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_sample) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_frame_err <= ~w_rx_s;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_parity_err = 1'b0;
`endif

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;
    assign rx_busy      = r_busy;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BPS_PARA, default 5208, system clocks per bit period; legal range 4..65535.
REQ-002 SHALL have port clk_in  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_in  input  1  asynchronous serial line, idle high, 8 data bits LSB first.
REQ-005 SHALL have port rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-006 SHALL have port rx_data  output  8  last accepted byte.
REQ-007 SHALL have port rx_valid  output  1  rx_data holds an unacknowledged byte.
REQ-008 SHALL have port rx_frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-009 SHALL have port rx_overrun  output  1  one-cycle pulse when a byte is accepted while rx_valid is high.
REQ-010 SHALL have port rx_parity_err  output  1  one-cycle pulse on parity mismatch.
REQ-011 SHALL have port rx_busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL pass rx_in through a two-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-013 SHALL detect a start edge as rx_s falling (previous 1, current 0) while in IDLE.
REQ-014 SHALL hold a 16-bit bit counter: cleared in the cycle the start edge is seen; otherwise increments; wraps to 0 at BPS_PARA-1.
REQ-015 SHALL sample rx_s in the cycle where the counter equals BPS_PARA>>1.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-017 SHALL move IDLE->START on the start edge.
REQ-018 SHALL, in START at the sample point, go to DATA if rx_s=0, else to IDLE as a false start with no flag.
REQ-019 SHALL, in DATA, shift one bit per sample point into bit 7 of a shift register, LSB first; after the 8th sample go to PARITY (macro) or STOP.
REQ-020 SHALL, in STOP at the sample point, always return to IDLE.
REQ-021 SHALL, on a valid stop bit (rx_s=1), load rx_data and set rx_valid in the next cycle.
REQ-022 SHALL, on an invalid stop bit (rx_s=0), pulse rx_frame_err for one cycle, leave rx_data and rx_valid unchanged, and discard the byte.
REQ-023 SHALL clear rx_valid in the cycle after rx_ack is sampled high; rx_ack while rx_valid is low has no effect.
REQ-024 SHALL, when a byte is accepted while rx_valid is high (not cleared in that same cycle by rx_ack), overwrite rx_data, keep rx_valid high, and pulse rx_overrun.
REQ-025 SHALL give accept priority over rx_ack when both occur in the same cycle: rx_valid stays high and no overrun is flagged.
REQ-026 SHALL require no high idle time between frames; because IDLE is re-entered at the stop-bit midpoint, a start edge after that point is detected.

Reset
REQ-027 SHALL, on rst_n_in low, asynchronously force: state IDLE; counter 0; shift register 0; rx_data 8'h00; all of rx_valid, rx_frame_err, rx_overrun, rx_parity_err and rx_busy 0; synchronizer flops 1.
REQ-028 SHALL, on reset during a frame, drop that frame; reception resumes on the next start edge after release.

Configuration
REQ-029 SHALL use macro UART_RX_PARITY_EN to enable even parity.
REQ-030 SHALL, with UART_RX_PARITY_EN defined, sample one parity bit in PARITY after the data bits.
REQ-031 SHALL, when the XOR of the 8 data bits and the parity bit is 1, pulse rx_parity_err together with the stop-bit evaluation; the byte is still accepted if the stop bit is valid.
REQ-032 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and tie rx_parity_err to 0.

Structure
REQ-033 SHALL place the state encoding (localparam enum, 3 bits), data width 8 and sync depth 2 in shared package uart_pkg.
REQ-034 SHALL implement synchronizer and falling-edge detect as sub-module uart_rx_sync (ports clk_in, rst_n_in, rx_in, rx_s, fall_edge).

Verification (BPS_PARA=16 unless noted)
REQ-035 SHALL cover: byte 8'hA5, 8N1, ideal timing -> rx_valid rises 1 cycle after stop midpoint, rx_data=8'hA5, no error pulses.
REQ-036 SHALL cover: low glitch of 4 cycles on idle line -> false start, rx_busy high then IDLE, no rx_valid, no flags.
REQ-037 SHALL cover: byte 8'h3C with stop bit 0 -> one rx_frame_err pulse, rx_valid stays 0, rx_data unchanged.
REQ-038 SHALL cover: 8'h11 then 8'h22 back-to-back, no rx_ack -> rx_overrun pulses once, rx_data=8'h22, rx_valid high.
REQ-039 SHALL cover: reset asserted mid-DATA of 8'hFF, then 8'h5A sent -> only 8'h5A received, all outputs at reset values during reset.
REQ-040 SHALL cover: with UART_RX_PARITY_EN, byte 8'h07 with parity bit 0 -> rx_parity_err pulse, rx_data=8'h07, rx_valid high.
